// File: rtl/key_debounce_repeat.sv
// ============================================================================
// Module      : key_debounce_repeat
// Description : Two-key debouncer with press event and optional auto-repeat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_debounce_repeat #(
  parameter int DEBOUNCE_CNT = 2_000_000,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_PER   = 10_000_000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  output logic       key_flag,
  output logic [1:0] key_value
);

  localparam int          c_CNT_W    = 26;
  localparam logic [25:0] c_DEB_LAST = 26'(DEBOUNCE_CNT - 1);
  localparam logic [25:0] c_DLY_LAST = 26'(REPEAT_DLY - 1);
  localparam logic [25:0] c_PER_LAST = 26'(REPEAT_PER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEB  = 3'd1,
    S_HOLD = 3'd2,
    S_RPT  = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [1:0]           r_pat;
  logic [1:0]           r_sync1;
  logic [1:0]           r_sync2;
  logic                 r_flag;
  logic [1:0]           r_value;

  logic [1:0]           w_p;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  // Sync FFs reset to "released" so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p       = ~r_sync2;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 26'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pat   <= 2'b00;
      r_flag  <= 1'b0;
      r_value <= 2'b00;
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_p != 2'b00) begin
            r_state <= S_DEB;
            r_pat   <= w_p;
            r_cnt   <= '0;
          end
        end
        S_DEB: begin
          if (w_p == 2'b00) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_p != r_pat) begin
            r_pat <= w_p;
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_flag  <= 1'b1;
            r_value <= r_pat;
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_HOLD: begin
          if (w_p != r_pat) begin
            r_state <= S_REL;
            r_cnt   <= '0;
          end else if (REPEAT_EN && (r_cnt == c_DLY_LAST)) begin
            // A pending flag from the previous cycle defers the repeat by one cycle.
            if (!r_flag) begin
              r_flag  <= 1'b1;
              r_value <= r_pat;
              r_state <= S_RPT;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RPT: begin
          if (w_p != r_pat) begin
            r_state <= S_REL;
            r_cnt   <= '0;
          end else if (r_cnt == c_PER_LAST) begin
            if (!r_flag) begin
              r_flag  <= 1'b1;
              r_value <= r_pat;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_REL: begin
          if (w_p != 2'b00) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign key_flag  = r_flag;
  assign key_value = r_value;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_repeat.sv
// ============================================================================
// Module      : tb_key_debounce_repeat
// Description : Randomized and directed checks of key_debounce_repeat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce_repeat;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  localparam int M_ARMED     = 0;
  localparam int M_PRESSED   = 1;
  localparam int M_RELEASING = 2;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic       flag_a;
  logic [1:0] val_a;
  logic       flag_b;
  logic [1:0] val_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0       = 0;

  // Reference state: [0] repeat enabled, [1] single pulse
  int         m_mode [2];
  int         m_run  [2];
  int         m_zc   [2];
  int         m_next [2];
  logic [1:0] m_s1   [2];
  logic [1:0] m_s2   [2];
  logic [1:0] m_prev [2];
  logic [1:0] m_pat  [2];
  logic       m_flag [2];
  logic [1:0] m_val  [2];

  int         q_off[$];
  logic [1:0] q_val[$];
  int         b_pulses;
  logic       prev_a;
  logic       prev_b;

  key_debounce_repeat #(
    .DEBOUNCE_CNT(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(1'b1)
  ) u_dut_rpt (
    .clk(clk), .rst(rst), .key_n(key_n), .key_flag(flag_a), .key_value(val_a)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CNT(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(1'b0)
  ) u_dut_one (
    .clk(clk), .rst(rst), .key_n(key_n), .key_flag(flag_b), .key_value(val_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event model: a press is accepted after DEB+1 identical nonzero samples,
  // repeats follow on a fixed schedule, and any pattern change requires DEB
  // consecutive all-released samples before the next press counts.
  task automatic model_step(input int i, input bit en, input logic r, input logic [1:0] k);
    logic [1:0] p;
    m_flag[i] = 1'b0;
    if (r) begin
      m_s1[i] = 2'b11; m_s2[i] = 2'b11;
      m_mode[i] = M_ARMED; m_run[i] = 0; m_zc[i] = 0;
      m_prev[i] = 2'b00; m_pat[i] = 2'b00; m_val[i] = 2'b00;
      return;
    end
    p = ~m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = k;
    m_run[i] = (p == m_prev[i]) ? m_run[i] + 1 : 1;
    m_prev[i] = p;
    case (m_mode[i])
      M_ARMED: begin
        if (p != 2'b00 && m_run[i] == DEB + 1) begin
          m_flag[i] = 1'b1; m_val[i] = p; m_pat[i] = p;
          m_mode[i] = M_PRESSED; m_next[i] = cyc + DLY;
        end
      end
      M_PRESSED: begin
        if (p != m_pat[i]) begin
          m_mode[i] = M_RELEASING; m_zc[i] = 0;
        end else if (en && cyc == m_next[i]) begin
          m_flag[i] = 1'b1; m_val[i] = m_pat[i]; m_next[i] = cyc + PER;
        end
      end
      default: begin
        m_zc[i] = (p == 2'b00) ? m_zc[i] + 1 : 0;
        if (m_zc[i] == DEB) m_mode[i] = M_ARMED;
      end
    endcase
  endtask

  task automatic tick(input logic r, input logic [1:0] k);
    rst   = r;
    key_n = k;
    @(posedge clk);
    cyc++;
    model_step(0, 1'b1, r, k);
    model_step(1, 1'b0, r, k);
    #1;
    check("flag_rpt", flag_a, m_flag[0]);
    check("value_rpt", val_a, m_val[0]);
    check("flag_one", flag_b, m_flag[1]);
    check("value_one", val_b, m_val[1]);
    check("b2b_rpt", flag_a & prev_a, 0);
    check("b2b_one", flag_b & prev_b, 0);
    prev_a = flag_a;
    prev_b = flag_b;
    if (flag_a) begin
      q_off.push_back(cyc - c0);
      q_val.push_back(val_a);
    end
    if (flag_b) b_pulses++;
  endtask

  task automatic start_window();
    c0 = cyc;
    q_off.delete();
    q_val.delete();
    b_pulses = 0;
  endtask

  task automatic hold(input logic [1:0] k, input int n);
    for (int j = 0; j < n; j++) tick(1'b0, k);
  endtask

  initial begin
    int exp_t[6];
    int len;
    logic [1:0] k;
    exp_t = '{7, 27, 35, 43, 51, 59};
    prev_a = 1'b0;
    prev_b = 1'b0;
    b_pulses = 0;

    for (int j = 0; j < 3; j++) tick(1'b1, 2'b11);
    check("reset_flag", flag_a, 0);
    check("reset_value", val_a, 0);
    hold(2'b11, 5);

    // Single short press of the decrement key
    start_window();
    hold(2'b10, 10);
    hold(2'b11, 20);
    check("s1_count", q_off.size(), 1);
    check("s1_time", q_off.size() > 0 ? q_off[0] : -1, 7);
    check("s1_value", q_val.size() > 0 ? q_val[0] : 2'b00, 2'b01);

    // Long hold of the increment key with auto-repeat
    start_window();
    hold(2'b01, 60);
    hold(2'b11, 20);
    check("s2_count", q_off.size(), 6);
    for (int j = 0; j < 6; j++) begin
      check("s2_time", q_off.size() > j ? q_off[j] : -1, exp_t[j]);
      check("s2_value", q_val.size() > j ? q_val[j] : 2'b00, 2'b10);
    end
    check("s2_single_pulse", b_pulses, 1);

    // Bounce every 2 cycles, then stable press
    c0 = cyc;
    for (int j = 0; j < 20; j++) tick(1'b0, ((j / 2) % 2 == 0) ? 2'b10 : 2'b11);
    start_window();
    hold(2'b10, 10);
    hold(2'b11, 20);
    check("s3_count", q_off.size(), 1);
    check("s3_time", q_off.size() > 0 ? q_off[0] : -1, DEB + 3);

    // Both keys at once
    start_window();
    hold(2'b00, 10);
    hold(2'b11, 20);
    check("s4_count", q_off.size(), 1);
    check("s4_value", q_val.size() > 0 ? q_val[0] : 2'b00, 2'b11);

    // Second key added while held; short release is not enough
    start_window();
    hold(2'b10, 12);
    hold(2'b00, 30);
    hold(2'b11, 2);
    hold(2'b10, 15);
    check("s5_locked", q_off.size(), 1);
    hold(2'b11, 10);
    start_window();
    hold(2'b10, 10);
    hold(2'b11, 20);
    check("s5_repress", q_off.size() > 0 ? q_off[0] : -1, 7);

    // Reset during a hold
    hold(2'b10, 12);
    tick(1'b1, 2'b10);
    check("s6_rst_flag", flag_a, 0);
    check("s6_rst_value", val_a, 0);
    start_window();
    hold(2'b10, 10);
    hold(2'b11, 20);
    check("s6_count", q_off.size(), 1);
    check("s6_time", q_off.size() > 0 ? q_off[0] : -1, 7);

    // Random bursts with occasional reset
    for (int n = 0; n < 300; n++) begin
      k   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 99) < 3) tick(1'b1, k);
      hold(k, len);
    end
    hold(2'b11, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_debounce_repeat.md
KEY_DEBOUNCE_REPEAT -- requirements
Module: key_debounce_repeat

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 2_000_000, stable-level cycles required to accept a press or release (20 ms @ 100 MHz).
REQ-002 Parameter REPEAT_DLY, default 50_000_000, hold cycles after the first pulse before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_PER, default 10_000_000, cycles between auto-repeat pulses (100 ms).
REQ-004 Parameter REPEAT_EN, default 1, enables auto-repeat (1) or single pulse per press (0).
REQ-005 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-006 rst  input  1  one clock; reset is synchronous and active-high.
REQ-007 key_n  input  2  raw asynchronous push-buttons, active-low; bit0 = decrement key, bit1 = increment key.
REQ-008 key_flag  output  1  single-cycle pulse: a debounced press or repeat event.
REQ-009 key_value  output  2  active-high pressed pattern for the event, valid when key_flag=1, held until next event.

Function
REQ-010 key_n SHALL pass a 2-FF synchronizer; pattern p = ~sync_out; no other logic SHALL sample key_n.
REQ-011 A single shared counter SHALL be 26 bits wide, cleared on every state transition, saturating never reached with defaults.
REQ-012 FSM states SHALL be IDLE, DEB, HOLD, RPT, REL.
REQ-013 IDLE: p != 0 -> DEB, latch p into pat, counter=0.
REQ-014 DEB: p == 0 -> IDLE; p != pat -> latch new p, counter=0, stay; counter == DEBOUNCE_CNT-1 with p == pat -> emit event (pat), go HOLD.
REQ-015 HOLD: p != pat -> REL; REPEAT_EN=1 and counter == REPEAT_DLY-1 -> emit event (pat), go RPT; REPEAT_EN=0 -> stay until p != pat.
REQ-016 RPT: p != pat -> REL, no further events; counter == REPEAT_PER-1 -> emit event (pat), counter=0, stay.
REQ-017 REL: p != 0 -> counter=0, stay; p == 0 for DEBOUNCE_CNT consecutive cycles -> IDLE; no events emitted in REL.
REQ-018 Emit = key_flag high for exactly one cycle, registered, and key_value = pat in that same cycle.
REQ-019 Latency: key_n edge to key_flag high SHALL be exactly DEBOUNCE_CNT+3 cycles for a clean press.
REQ-020 Both keys pressed: pat = 2'b11 SHALL be emitted unchanged; downstream ignores it.
REQ-021 Second key added while held (e.g. 01 -> 11): p != pat -> REL; a new event requires full release then re-press.
REQ-022 Glitches shorter than DEBOUNCE_CNT cycles in DEB or REL SHALL produce no event.
REQ-023 key_flag SHALL never be high on two consecutive cycles.

Reset
REQ-024 While rst=1: state=IDLE, counter=0, pat=2'b00, key_flag=0, key_value=2'b00, synchronizer FFs=2'b11 (released).
REQ-025 rst asserted mid-press SHALL abort without event; after release of rst with key still held, a fresh DEBOUNCE_CNT debounce SHALL precede the first event.

Verification (DEBOUNCE_CNT=4, REPEAT_DLY=20, REPEAT_PER=8, REPEAT_EN=1)
REQ-026 key_n=2'b10 (bit0 pressed) held 10 cycles then released -> one key_flag pulse at cycle 7 after edge, key_value=2'b01; no further pulses.
REQ-027 key_n bit1 pressed and held 60 cycles -> pulses at edge+7, +27, +35, +43, +51, +59 with key_value=2'b10 each; none after release.
REQ-028 key_n bit0 bouncing low/high every 2 cycles for 20 cycles, then stable low -> exactly one pulse, DEBOUNCE_CNT+3 cycles after final stable edge.
REQ-029 Both keys pressed simultaneously and held 10 cycles -> one pulse with key_value=2'b11.
REQ-030 Bit0 held, pulse seen, then bit1 added -> no pulse until both released for 4 cycles and a key re-pressed; rst pulsed during a hold -> key_flag=0, key_value=2'b00 next cycle, new pulse only after 7 cycles of continued press.
REQ-031 REPEAT_EN=0, bit1 held 60 cycles -> exactly one pulse, key_value=2'b10.
